calc_seq_ctrl: RTL and testbench

- Keypad-driven sequencer that sits in front of the calculator ALU/display path.
- Assembles decimal operand A, operator and operand B from single-cycle key events, then holds a/b/op stable for one execute cycle.
- Captures the 14-bit ALU result and supports chaining the result into the next operation.
- Drives a display-select code so the top level shows A, B, the result, or an error pattern.

---
 rtl/calc_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// Keypad sequencer for the calculator: builds operand A, operator and operand B
// from key strobes, runs one execute cycle, then latches or rejects the ALU result.
module calc_seq_ctrl #(
  parameter int DW         = 10,
  parameter int RW         = 14,
  parameter int MAX_DIGITS = 3,
  parameter int RES_MAX    = 9999
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  input  logic [4:0]    key_code,
  output logic          key_ready,
  input  logic [RW-1:0] alu_res,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [2:0]    op,
  output logic [RW-1:0] result,
  output logic [1:0]    show_sel,
  output logic          err
);

  localparam int CW        = $clog2(MAX_DIGITS + 1);
  localparam int CHAIN_MAX = (10 ** MAX_DIGITS) - 1;

  localparam logic [2:0] ST_ENT_A = 3'd0;
  localparam logic [2:0] ST_ENT_B = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [RW-1:0] result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          is_digit, is_op, is_eq, is_clr;
  logic          room;
  logic [DW-1:0] digit_val;

  assign key_ready = (state_q != ST_EXEC);
  assign accept    = key_valid & key_ready;
  assign is_digit  = (key_code <= 5'd9);
  assign is_op     = (key_code[4:3] == 2'b10);
  assign is_eq     = (key_code == 5'd24);
  assign is_clr    = (key_code == 5'd25);
  assign digit_val = DW'(key_code[3:0]);
  assign room      = (cnt_q < CW'(MAX_DIGITS));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    cnt_d    = cnt_q;

    if (state_q == ST_EXEC) begin
      // Keys are not accepted here; only the ALU verdict matters.
      if (alu_res <= RW'(RES_MAX)) begin
        result_d = alu_res;
        state_d  = ST_SHOW;
      end else begin
        result_d = '0;
        state_d  = ST_ERR;
      end
    end else if (accept && is_clr) begin
      state_d  = ST_ENT_A;
      a_d      = '0;
      b_d      = '0;
      op_d     = '0;
      result_d = '0;
      cnt_d    = '0;
    end else if (accept) begin
      case (state_q)
        ST_ENT_A: begin
          if (is_digit && room) begin
            a_d   = a_q * DW'(10) + digit_val;
            cnt_d = cnt_q + CW'(1);
          end else if (is_op) begin
            op_d    = key_code[2:0];
            b_d     = '0;
            cnt_d   = '0;
            state_d = ST_ENT_B;
          end
        end
        ST_ENT_B: begin
          if (is_digit && room) begin
            b_d   = b_q * DW'(10) + digit_val;
            cnt_d = cnt_q + CW'(1);
          end else if (is_op && (cnt_q == '0)) begin
            op_d = key_code[2:0];
          end else if (is_eq && (cnt_q != '0)) begin
            state_d = ST_EXEC;
          end
        end
        ST_SHOW: begin
          if (is_digit) begin
            a_d     = digit_val;
            b_d     = '0;
            cnt_d   = CW'(1);
            state_d = ST_ENT_A;
          end else if (is_op) begin
            // Chaining only works if the result still fits an operand.
            if (result_q <= RW'(CHAIN_MAX)) begin
              a_d     = result_q[DW-1:0];
              op_d    = key_code[2:0];
              b_d     = '0;
              cnt_d   = '0;
              state_d = ST_ENT_B;
            end else begin
              state_d = ST_ERR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ENT_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_ENT_A: show_sel = 2'd0;
      ST_ENT_B: show_sel = 2'd1;
      ST_EXEC:  show_sel = 2'd1;
      ST_SHOW:  show_sel = 2'd2;
      default:  show_sel = 2'd3;
    endcase
  end

  assign err    = (state_q == ST_ERR);
  assign a      = a_q;
  assign b      = b_q;
  assign op     = op_q;
  assign result = result_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed key sequences plus random key traffic,
// every cycle compared against a key-by-key behavioural model of the calculator.
module tb_calc_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ready;
  logic [13:0] alu_res;
  logic [9:0]  a;
  logic [9:0]  b;
  logic [2:0]  op;
  logic [13:0] result;
  logic [1:0]  show_sel;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef enum {M_ENTER_A, M_ENTER_B, M_EXECUTE, M_SHOWING, M_ERROR} mode_t;
  mode_t mMode;
  int    mA, mB, mOp, mRes, mDigits;

  calc_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .alu_res  (alu_res),
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (result),
    .show_sel (show_sel),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU; ops 4 and 5 give fixed values to reach overflow and chain limits.
  function automatic int aluModel(input int x, input int y, input int o);
    int r;
    case (o)
      0: r = x + y;
      1: r = (x > y) ? x - y : 0;
      2: r = x * y;
      3: r = (y != 0) ? x / y : 0;
      4: r = 12000;
      5: r = 1500;
      default: r = x + y;
    endcase
    return r & 16'h3FFF;
  endfunction

  always_comb alu_res = 14'(aluModel(int'(a), int'(b), int'(op)));

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mMode = M_ENTER_A; mA = 0; mB = 0; mOp = 0; mRes = 0; mDigits = 0;
  endtask

  task automatic modelStep(input bit valid, input int code);
    int r;
    if (mMode == M_EXECUTE) begin
      r = aluModel(mA, mB, mOp);
      if (r <= 9999) begin mRes = r; mMode = M_SHOWING; end
      else begin mRes = 0; mMode = M_ERROR; end
    end else if (valid) begin
      if (code == 25) begin
        modelReset();
      end else begin
        case (mMode)
          M_ENTER_A:
            if (code <= 9) begin
              if (mDigits < 3) begin mA = mA * 10 + code; mDigits++; end
            end else if (code >= 16 && code <= 23) begin
              mOp = code - 16; mB = 0; mDigits = 0; mMode = M_ENTER_B;
            end
          M_ENTER_B:
            if (code <= 9) begin
              if (mDigits < 3) begin mB = mB * 10 + code; mDigits++; end
            end else if (code >= 16 && code <= 23) begin
              if (mDigits == 0) mOp = code - 16;
            end else if (code == 24 && mDigits > 0) begin
              mMode = M_EXECUTE;
            end
          M_SHOWING:
            if (code <= 9) begin
              mA = code; mDigits = 1; mB = 0; mMode = M_ENTER_A;
            end else if (code >= 16 && code <= 23) begin
              if (mRes <= 999) begin
                mA = mRes; mOp = code - 16; mB = 0; mDigits = 0; mMode = M_ENTER_B;
              end else begin
                mMode = M_ERROR;
              end
            end
          default: ;
        endcase
      end
    end
  endtask

  task automatic compareAll(input string ctx);
    int expSel;
    case (mMode)
      M_ENTER_A: expSel = 0;
      M_ENTER_B, M_EXECUTE: expSel = 1;
      M_SHOWING: expSel = 2;
      default: expSel = 3;
    endcase
    checkOutput({ctx, ".a"}, int'(a), mA);
    checkOutput({ctx, ".b"}, int'(b), mB);
    checkOutput({ctx, ".op"}, int'(op), mOp);
    checkOutput({ctx, ".result"}, int'(result), mRes);
    checkOutput({ctx, ".show_sel"}, int'(show_sel), expSel);
    checkOutput({ctx, ".err"}, int'(err), (mMode == M_ERROR) ? 1 : 0);
    checkOutput({ctx, ".key_ready"}, int'(key_ready), (mMode == M_EXECUTE) ? 0 : 1);
  endtask

  // One clock cycle: drive the key at the falling edge, compare just after the rising edge.
  task automatic applyStimulus(input bit valid, input int code, input string ctx);
    @(negedge clk);
    key_valid = valid;
    key_code  = 5'(code);
    @(posedge clk);
    modelStep(valid, code);
    #1;
    key_valid = 1'b0;
    compareAll(ctx);
  endtask

  task automatic pressKeys(input int keys[$], input string ctx);
    foreach (keys[i]) applyStimulus(1'b1, keys[i], ctx);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int code;
    bit valid;
    int sel;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 5'd0;
    modelReset();
    #12;
    compareAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    pressKeys('{1, 2, 3, 16, 4, 5, 24}, "basic");
    checkOutput("basic.exec_a", int'(a), 123);
    checkOutput("basic.exec_b", int'(b), 45);
    checkOutput("basic.exec_op", int'(op), 0);
    checkOutput("basic.exec_ready", int'(key_ready), 0);
    applyStimulus(1'b0, 0, "basic_exec");
    checkOutput("basic.result", int'(result), 168);
    checkOutput("basic.show_sel", int'(show_sel), 2);

    pressKeys('{18, 2, 24}, "chain");
    checkOutput("chain.a", int'(a), 168);
    checkOutput("chain.op", int'(op), 2);
    checkOutput("chain.b", int'(b), 2);
    applyStimulus(1'b0, 0, "chain_exec");
    checkOutput("chain.result", int'(result), 336);

    pressKeys('{25, 9, 9, 9, 9, 17, 19, 7, 24}, "limit");
    checkOutput("limit.a", int'(a), 999);
    checkOutput("limit.op", int'(op), 3);
    checkOutput("limit.b", int'(b), 7);
    checkOutput("limit.exec_ready", int'(key_ready), 0);
    applyStimulus(1'b0, 0, "limit_exec");
    checkOutput("limit.result", int'(result), 142);

    pressKeys('{25, 1, 21, 1, 24}, "big");
    applyStimulus(1'b0, 0, "big_exec");
    checkOutput("big.result", int'(result), 1500);
    pressKeys('{16}, "big_chain");
    checkOutput("big_chain.show_sel", int'(show_sel), 3);
    pressKeys('{5, 24, 17}, "err_ignore");
    checkOutput("err_ignore.err", int'(err), 1);
    pressKeys('{25}, "err_clear");
    checkOutput("err_clear.show_sel", int'(show_sel), 0);
    checkOutput("err_clear.a", int'(a), 0);

    pressKeys('{1, 20, 1, 24}, "ovf");
    applyStimulus(1'b0, 0, "ovf_exec");
    checkOutput("ovf.err", int'(err), 1);
    checkOutput("ovf.result", int'(result), 0);

    pressKeys('{25, 1, 16, 2, 24}, "drop");
    applyStimulus(1'b1, 5, "drop_exec");
    checkOutput("drop.b", int'(b), 2);
    checkOutput("drop.result", int'(result), 3);

    pressKeys('{25, 3, 16, 24, 30}, "eq_empty");
    checkOutput("eq_empty.show_sel", int'(show_sel), 1);
    checkOutput("eq_empty.ready", int'(key_ready), 1);

    // Asynchronous reset landing in the execute cycle.
    pressKeys('{4, 24}, "abort");
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll("abort_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, "abort_after");

    for (int i = 0; i < 3000; i++) begin
      sel   = $urandom_range(0, 99);
      valid = ($urandom_range(0, 99) < 85);
      if (sel < 45)      code = $urandom_range(0, 9);
      else if (sel < 65) code = 16 + $urandom_range(0, 7);
      else if (sel < 78) code = 24;
      else if (sel < 82) code = 25;
      else if (sel < 91) code = $urandom_range(10, 15);
      else               code = $urandom_range(26, 31);
      applyStimulus(valid, code, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
